// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared definitions for the data-memory path: size encodings, responder
// FSM state type and the byte-lane mask helper.
package ysyx_22050612_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // 2^size ones placed at the byte offset; only meaningful for aligned accesses.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/ysyx_22050612_dmem_array.sv
// Single-port DEPTH x 64 storage: combinational read, synchronous byte-enabled write.
module ysyx_22050612_dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          wen,
  input  logic [7:0]    be,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wen && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/ysyx_22050612_dmem_resp.sv
// Data-memory responder: valid/ready request, fixed-latency response with
// alignment/range checking and load extension.
module ysyx_22050612_dmem_resp
  import ysyx_22050612_mem_pkg::*;
#(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam int          CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

  state_t        state;
  logic [CW-1:0] cnt;

  logic          accept;
  logic [63:0]   off_addr;
  logic [2:0]    off;
  logic          misaligned;
  logic          out_of_range;
  logic          err;
  logic [63:0]   arr_rdata;
  logic [63:0]   shifted;
  logic [63:0]   load_val;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // Subtracting first keeps the upper bound free of BASE+size overflow.
  assign off_addr     = req_addr - BASE;
  assign out_of_range = (req_addr < BASE) || (off_addr >= LIMIT);
  assign off          = req_addr[2:0];

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign err = misaligned || out_of_range;

  ysyx_22050612_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .addr  (off_addr[AW+2:3]),
    .wen   (accept && req_wen && !err),
    .be    (byte_mask(req_size, off)),
    .wdata (req_wdata << {off, 3'b000}),
    .rdata (arr_rdata)
  );

  assign shifted = arr_rdata >> {off, 3'b000};

  always_comb begin
    load_val = shifted;
    case (req_size)
      SZ_B:    load_val = req_sext ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      SZ_H:    load_val = req_sext ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      SZ_W:    load_val = req_sext ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_err   <= err;
            resp_rdata <= (err || req_wen) ? 64'd0 : load_val;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CW'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_dmem_resp.sv
// Directed and scoreboard-checked bench for the data-memory responder,
// using one LATENCY=1 and one LATENCY=4 instance.
module tb_ysyx_22050612_dmem_resp;
  import ysyx_22050612_mem_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_sext = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;

  logic        req_valid1 = 1'b0, resp_ready1 = 1'b1;
  logic        req_ready1, resp_valid1, resp_err1;
  logic [63:0] resp_rdata1;
  logic        req_valid4 = 1'b0, resp_ready4 = 1'b1;
  logic        req_ready4, resp_valid4, resp_err4;
  logic [63:0] resp_rdata4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22050612_dmem_resp #(.BASE(BASE), .DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_wen(req_wen), .req_size(req_size), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
    .resp_ready(resp_ready1), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  ysyx_22050612_dmem_resp #(.BASE(BASE), .DEPTH(1024), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_wen(req_wen), .req_size(req_size), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid4),
    .resp_ready(resp_ready4), .resp_rdata(resp_rdata4), .resp_err(resp_err4)
  );

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        sext;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  logic [7:0] sbb [0:16][0:7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  function automatic logic rdyOf(input int which);
    return (which == 4) ? req_ready4 : req_ready1;
  endfunction

  function automatic logic vldOf(input int which);
    return (which == 4) ? resp_valid4 : resp_valid1;
  endfunction

  // One full transaction with resp_ready held high; lat counts edges from
  // the acceptance edge (inclusive) to the first edge after which resp_valid is seen.
  task automatic applyStimulus(input int which, input logic wen, input logic [1:0] size,
                               input logic sext, input logic [63:0] addr, input logic [63:0] wdata,
                               output logic [63:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!rdyOf(which) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("ready_timeout", 64'(rdyOf(which)), 64'd1);
    req_wen = wen; req_size = size; req_sext = sext; req_addr = addr; req_wdata = wdata;
    if (which == 4) begin req_valid4 = 1'b1; resp_ready4 = 1'b1; end
    else            begin req_valid1 = 1'b1; resp_ready1 = 1'b1; end
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_valid4 = 1'b0;
    req_wen = ~wen; req_size = ~size; req_sext = ~sext; req_addr = ~addr; req_wdata = ~wdata;
    lat = 1;
    while (!vldOf(which) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = (which == 4) ? resp_rdata4 : resp_rdata1;
    err   = (which == 4) ? resp_err4 : resp_err1;
    @(posedge clk); #1;
  endtask

  task automatic addVec(input logic wen, input logic [1:0] size, input logic sext,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wen = wen; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vq.push_back(v);
  endtask

  function automatic logic [63:0] slotAddr(input int idx);
    return (idx == 16) ? (BASE + 64'h1FF8) : (BASE + 64'h100 + 64'(idx) * 64'd8);
  endfunction

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    logic [63:0] v4a, v4b;

    #1 rst = 1'b1;
    #1;
    checkOutput("reset_req_ready", 64'(req_ready1), 64'd1);
    checkOutput("reset_resp_valid", 64'(resp_valid1), 64'd0);
    checkOutput("reset_resp_rdata", resp_rdata1, 64'd0);
    checkOutput("reset_resp_err", 64'(resp_err1), 64'd0);
    checkOutput("reset4_req_ready", 64'(req_ready4), 64'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    addVec(1, SZ_D, 0, 64'h8000_0010, 64'h1122_3344_5566_7788, 64'd0, 0);
    addVec(0, SZ_D, 1, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 0);
    addVec(1, SZ_B, 0, 64'h8000_0013, 64'hFFFF_FFFF_FFFF_FF80, 64'd0, 0);
    addVec(0, SZ_B, 1, 64'h8000_0013, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 0);
    addVec(0, SZ_B, 0, 64'h8000_0013, 64'd0, 64'h0000_0000_0000_0080, 0);
    addVec(0, SZ_W, 0, 64'h8000_0010, 64'd0, 64'h0000_0000_8066_7788, 0);
    addVec(0, SZ_W, 1, 64'h8000_0010, 64'd0, 64'hFFFF_FFFF_8066_7788, 0);
    addVec(0, SZ_H, 1, 64'h8000_0011, 64'd0, 64'd0, 1);
    addVec(1, SZ_D, 0, 64'h8000_0000, 64'hA5A5_0000_1234_5678, 64'd0, 0);
    addVec(1, SZ_D, 0, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    addVec(1, SZ_D, 0, 64'h8000_0004, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    addVec(0, SZ_D, 0, 64'h8000_0000, 64'd0, 64'hA5A5_0000_1234_5678, 0);
    addVec(0, SZ_H, 1, 64'h8000_0016, 64'd0, 64'h0000_0000_0000_1122, 0);
    addVec(1, SZ_H, 0, 64'h8000_0016, 64'h0000_0000_0000_BEEF, 64'd0, 0);
    addVec(0, SZ_H, 1, 64'h8000_0016, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 0);
    addVec(0, SZ_D, 0, 64'h8000_0010, 64'd0, 64'hBEEF_3344_8066_7788, 0);
    addVec(0, SZ_W, 0, 64'h8000_0012, 64'd0, 64'd0, 1);
    addVec(1, SZ_D, 0, 64'h8000_1FF8, 64'hCAFE_F00D_DEAD_BEEF, 64'd0, 0);
    addVec(0, SZ_D, 0, 64'h8000_1FF8, 64'd0, 64'hCAFE_F00D_DEAD_BEEF, 0);
    addVec(0, SZ_W, 1, 64'h8000_1FFC, 64'd0, 64'hFFFF_FFFF_CAFE_F00D, 0);
    addVec(0, SZ_D, 0, 64'h8000_2000, 64'd0, 64'd0, 1);
    addVec(1, SZ_W, 0, 64'h8000_2000, 64'h1234_5678, 64'd0, 1);
    addVec(0, SZ_B, 0, 64'h0000_0000_0000_0010, 64'd0, 64'd0, 1);

    foreach (vq[i]) begin
      applyStimulus(1, vq[i].wen, vq[i].size, vq[i].sext, vq[i].addr, vq[i].wdata, rd, er, lat);
      checkOutput($sformatf("vec%0d_rdata", i), rd, vq[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), 64'(er), 64'(vq[i].exp_err));
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
    end

    // Latency-4 instance: stalled response, blocked request, then reset in WAIT.
    v4a = 64'h0123_4567_89AB_CDEF;
    v4b = 64'hFEDC_BA98_7654_3210;
    applyStimulus(4, 1, SZ_D, 0, 64'h8000_0020, v4a, rd, er, lat);
    checkOutput("l4_store_latency", 64'(lat), 64'd4);
    checkOutput("l4_store_err", 64'(er), 64'd0);

    @(negedge clk);
    req_wen = 0; req_size = SZ_D; req_sext = 0; req_addr = 64'h8000_0020; req_wdata = '0;
    req_valid4 = 1'b1; resp_ready4 = 1'b0;
    @(posedge clk); #1;
    req_wen = 1; req_addr = 64'h8000_0028; req_wdata = v4b;
    lat = 1;
    while (!resp_valid4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("l4_load_latency", 64'(lat), 64'd4);
    checkOutput("l4_ready_busy", 64'(req_ready4), 64'd0);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("l4_stall%0d_valid", s), 64'(resp_valid4), 64'd1);
      checkOutput($sformatf("l4_stall%0d_rdata", s), resp_rdata4, v4a);
      checkOutput($sformatf("l4_stall%0d_ready", s), 64'(req_ready4), 64'd0);
    end
    @(negedge clk);
    resp_ready4 = 1'b1;
    @(posedge clk); #1;
    checkOutput("l4_handshake_ready", 64'(req_ready4), 64'd1);
    checkOutput("l4_handshake_valid", 64'(resp_valid4), 64'd0);
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    checkOutput("l4_next_accept_ready", 64'(req_ready4), 64'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("l4_rst_valid", 64'(resp_valid4), 64'd0);
    checkOutput("l4_rst_ready", 64'(req_ready4), 64'd1);
    checkOutput("l4_rst_err", 64'(resp_err4), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4, 0, SZ_D, 0, 64'h8000_0028, 64'd0, rd, er, lat);
    checkOutput("l4_after_rst_rdata", rd, v4b);
    checkOutput("l4_after_rst_latency", 64'(lat), 64'd4);

    // Scoreboard-checked random traffic on a window plus the top word.
    for (int w = 0; w <= 16; w++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) sbb[w][b] = d[8*b +: 8];
      applyStimulus(1, 1, SZ_D, 0, slotAddr(w), d, rd, er, lat);
      checkOutput($sformatf("init%0d_err", w), 64'(er), 64'd0);
    end
    for (int t = 0; t < 150; t++) begin
      int          idx, off, n, kind;
      logic        wen, sext, exp_err, oor;
      logic [1:0]  size;
      logic [63:0] addr, wdata, exp;
      idx   = $urandom_range(0, 16);
      off   = $urandom_range(0, 7);
      size  = 2'($urandom_range(0, 3));
      wen   = 1'($urandom_range(0, 1));
      sext  = 1'($urandom_range(0, 1));
      wdata = {$urandom, $urandom};
      kind  = $urandom_range(0, 9);
      n     = 1 << size;
      if (kind == 0)      begin addr = BASE + 64'h2000 + 64'(off); oor = 1'b1; end
      else if (kind == 1) begin addr = BASE - 64'd8 + 64'(off);    oor = 1'b1; end
      else begin
        if ((off % n) != 0 && kind < 8) off = off - (off % n);
        addr = slotAddr(idx) + 64'(off);
        oor  = 1'b0;
      end
      exp_err = oor || ((off % n) != 0);
      exp = 64'd0;
      if (!exp_err && wen) begin
        for (int k = 0; k < n; k++) sbb[idx][off + k] = wdata[8*k +: 8];
      end else if (!exp_err) begin
        for (int k = 0; k < n; k++) exp = exp | (64'(sbb[idx][off + k]) << (8 * k));
        if (size != SZ_D && sext && sbb[idx][off + n - 1][7])
          exp = exp | ~((64'd1 << (8 * n)) - 64'd1);
      end
      applyStimulus(1, wen, size, sext, addr, wdata, rd, er, lat);
      checkOutput($sformatf("rnd%0d_rdata", t), rd, exp);
      checkOutput($sformatf("rnd%0d_err", t), 64'(er), 64'(exp_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
